reg_writeback: RTL and testbench

- Write-back sequencer on the initiator side of the register-file write port.
- Accepts completed results from the ALU path and the memory (load) path.
- Sign- or zero-extends and aligns load data, then queues results in a small FIFO.
- Drains one write per cycle as wb_flag/rd/data into the register file; also reports pending-write hazards for decode.

---
 rtl/reg_writeback.sv | 144 ++++++++++++++
 tb/tb_reg_writeback.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Write-back sequencer: extends loads, queues ALU/load results, drains one write per cycle.
// Latency: accepted at edge N, strobed at N+1 at the earliest. Readies come only from the registered count; rdy_in=0 freezes the block.
module reg_writeback #(
  parameter int LEN   = 32,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy_in,
  input  logic           alu_valid,
  input  logic [4:0]     alu_rd,
  input  logic [LEN-1:0] alu_data,
  output logic           alu_ready,
  input  logic           mem_valid,
  input  logic [4:0]     mem_rd,
  input  logic [2:0]     mem_funct3,
  input  logic [1:0]     mem_offset,
  input  logic [LEN-1:0] mem_word,
  output logic           mem_ready,
  input  logic [4:0]     rs1,
  input  logic [4:0]     rs2,
  output logic           rs1_busy,
  output logic           rs2_busy,
  output logic           wb_flag,
  output logic [4:0]     rd,
  output logic [LEN-1:0] data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [4:0]     ent_rd_q  [DEPTH];
  logic [4:0]     ent_rd_d  [DEPTH];
  logic [LEN-1:0] ent_dat_q [DEPTH];
  logic [LEN-1:0] ent_dat_d [DEPTH];
  logic           wb_flag_q, wb_flag_d;
  logic [4:0]     rd_q, rd_d;
  logic [LEN-1:0] data_q, data_d;

  logic           mem_push, alu_push, pop;
  logic [7:0]     byte_sel;
  logic [15:0]    half_sel;
  logic [LEN-1:0] load_dat;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  slot_off;
  logic           rs1_hit, rs2_hit;

  // Worst case (both accepted, no pop) still fits because alu needs one more free slot than mem.
  assign mem_ready = rdy_in && (count_q <= CW'(DEPTH - 1));
  assign alu_ready = rdy_in && (count_q <= CW'(DEPTH - 2));

  assign mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign pop      = rdy_in && (count_q != '0);

  always_comb begin
    byte_sel = mem_word[8*mem_offset +: 8];
    half_sel = mem_word[16*mem_offset[1] +: 16];
    case (mem_funct3)
      3'b000:  load_dat = {{(LEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_dat = {{(LEN-16){half_sel[15]}}, half_sel};
      3'b100:  load_dat = {{(LEN-8){1'b0}}, byte_sel};
      3'b101:  load_dat = {{(LEN-16){1'b0}}, half_sel};
      default: load_dat = mem_word;
    endcase
  end

  // The load is the older instruction, so it takes the tail slot before the ALU result.
  always_comb begin
    ent_rd_d  = ent_rd_q;
    ent_dat_d = ent_dat_q;
    wr_ptr    = tail_q;
    if (mem_push) begin
      ent_rd_d[wr_ptr]  = mem_rd;
      ent_dat_d[wr_ptr] = load_dat;
      wr_ptr            = wr_ptr + AW'(1);
    end
    if (alu_push) begin
      ent_rd_d[wr_ptr]  = alu_rd;
      ent_dat_d[wr_ptr] = alu_data;
      wr_ptr            = wr_ptr + AW'(1);
    end
    tail_d = wr_ptr;

    head_d    = head_q;
    wb_flag_d = 1'b0;
    rd_d      = rd_q;
    data_d    = data_q;
    if (pop) begin
      wb_flag_d = 1'b1;
      rd_d      = ent_rd_q[head_q];
      data_d    = ent_dat_q[head_q];
      head_d    = head_q + AW'(1);
    end
    count_d = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  // A slot is live when its distance from head is below count; the write just strobed is still in flight.
  always_comb begin
    rs1_hit  = wb_flag_q && (rd_q == rs1);
    rs2_hit  = wb_flag_q && (rd_q == rs2);
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = AW'(i) - head_q;
      if ({1'b0, slot_off} < count_q) begin
        if (ent_rd_q[i] == rs1) rs1_hit = 1'b1;
        if (ent_rd_q[i] == rs2) rs2_hit = 1'b1;
      end
    end
    rs1_busy = (rs1 != 5'd0) && rs1_hit;
    rs2_busy = (rs2 != 5'd0) && rs2_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      wb_flag_q <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd_q[i]  <= '0;
        ent_dat_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      wb_flag_q <= wb_flag_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      ent_rd_q  <= ent_rd_d;
      ent_dat_q <= ent_dat_d;
    end
  end

  assign wb_flag = wb_flag_q;
  assign rd      = rd_q;
  assign data    = data_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed cases then random traffic, scored against a queue-based model.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic        clk;
  logic        rst;
  logic        rdy_in;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_offset;
  logic [31:0] mem_word;
  logic        mem_ready;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        wb_flag;
  logic [4:0]  rd;
  logic [31:0] data;

  logic [31:0] mem_exp;
  wb_t         sb[$];
  int          head = 0;
  int          flush_idx = 0;
  logic        exp_flag = 1'b0;
  logic [4:0]  last_rd = '0;
  logic [31:0] last_data = '0;
  int          checks = 0;
  int          errors = 0;

  reg_writeback #(.LEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_funct3(mem_funct3), .mem_offset(mem_offset),
    .mem_word(mem_word), .mem_ready(mem_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_flag(wb_flag), .rd(rd), .data(data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic int base_idx();
    return (head > flush_idx) ? head : flush_idx;
  endfunction

  function automatic logic busy_model(input logic [4:0] q, input int b);
    logic hit;
    hit = exp_flag && (last_rd == q);
    for (int i = b; i < sb.size(); i++)
      if (sb[i].rd == q) hit = 1'b1;
    return (q != 5'd0) && hit;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue occupancy is the list of results accepted but not yet written.
  always @(posedge clk or negedge rst) begin
    int  b, cnt;
    wb_t e;
    if (!rst) begin
      flush_idx = sb.size();
      exp_flag  = 1'b0;
    end else begin
      b        = base_idx();
      cnt      = sb.size() - b;
      exp_flag = rdy_in && (cnt > 0);
      if (rdy_in) begin
        if (mem_valid && cnt <= DEPTH - 1 && mem_rd != 5'd0) begin
          e.rd = mem_rd; e.data = mem_exp; sb.push_back(e);
        end
        if (alu_valid && cnt <= DEPTH - 2 && alu_rd != 5'd0) begin
          e.rd = alu_rd; e.data = alu_data; sb.push_back(e);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each expected strobe and checks readies and hazards.
  always begin
    int b, pend;
    @(negedge clk or negedge rst);
    #1;
    if (!rst) begin
      chk("reset_outputs", 64'({wb_flag, rd, data}), 64'd0);
      chk("reset_readies", 64'({mem_ready, alu_ready}), 64'({rdy_in, rdy_in}));
      last_rd   = '0;
      last_data = '0;
    end else begin
      b = base_idx();
      chk("wb_flag", 64'(wb_flag), 64'(exp_flag));
      if (exp_flag && sb.size() > b) begin
        chk("wb_rd_data", 64'({rd, data}), 64'({sb[b].rd, sb[b].data}));
        last_rd   = sb[b].rd;
        last_data = sb[b].data;
        head      = b + 1;
      end else begin
        chk("hold_rd_data", 64'({rd, data}), 64'({last_rd, last_data}));
      end
      b    = base_idx();
      pend = sb.size() - b;
      chk("mem_ready", 64'(mem_ready), 64'(rdy_in && pend <= DEPTH - 1));
      chk("alu_ready", 64'(alu_ready), 64'(rdy_in && pend <= DEPTH - 2));
      chk("rs1_busy", 64'(rs1_busy), 64'(busy_model(rs1, b)));
      chk("rs2_busy", 64'(rs2_busy), 64'(busy_model(rs2, b)));
    end
  end

  task automatic drive(input logic r, input logic mv, input logic [4:0] mrd, input logic [2:0] f3,
                       input logic [1:0] off, input logic [31:0] mw, input logic [31:0] mx,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic [4:0] q1, input logic [4:0] q2);
    @(negedge clk);
    #2;
    rdy_in = r; mem_valid = mv; mem_rd = mrd; mem_funct3 = f3; mem_offset = off;
    mem_word = mw; mem_exp = mx; alu_valid = av; alu_rd = ard; alu_data = ad;
    rs1 = q1; rs2 = q2;
  endtask

  task automatic idle(input int n, input logic [4:0] q1);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'b0, 5'd0, 3'd2, 2'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, 5'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [2:0]  f3;
    logic [1:0]  off;
    rst = 1'b0; rdy_in = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_funct3 = '0; mem_offset = '0; mem_word = '0;
    mem_exp = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    drive(1, 0, 0, 2, 0, 0, 0, 1, 5'd5, 32'h0000_1234, 5'd5, 0);
    idle(3, 5'd5);

    w = 32'h8081_F2F3;
    drive(1, 1, 5'd1, 3'd0, 2'd0, w, 32'hFFFF_FFF3, 0, 0, 0, 5'd1, 5'd2);
    drive(1, 1, 5'd2, 3'd4, 2'd2, w, 32'h0000_0081, 0, 0, 0, 5'd1, 5'd2);
    drive(1, 1, 5'd3, 3'd1, 2'd2, w, 32'hFFFF_8081, 0, 0, 0, 5'd3, 5'd4);
    drive(1, 1, 5'd4, 3'd5, 2'd0, w, 32'h0000_F2F3, 0, 0, 0, 5'd4, 5'd5);
    drive(1, 1, 5'd5, 3'd2, 2'd1, w, 32'h8081_F2F3, 0, 0, 0, 5'd5, 5'd1);
    idle(4, 5'd5);

    drive(1, 1, 5'd3, 3'd2, 2'd0, 32'hAA, 32'hAA, 1, 5'd3, 32'hBB, 5'd3, 5'd3);
    idle(4, 5'd3);

    for (int i = 0; i < 4; i++)
      drive(1, 1, 5'd6, 3'd2, 2'd0, 32'h600 + i, 32'h600 + i, 1, 5'd7, 32'h700 + i, 5'd6, 5'd7);
    for (int i = 0; i < 2; i++)
      drive(0, 1, 5'd8, 3'd2, 2'd0, 32'h800, 32'h800, 1, 5'd8, 32'h801, 5'd6, 5'd8);
    idle(6, 5'd7);

    drive(1, 0, 0, 2, 0, 0, 0, 1, 5'd0, 32'h0000_FFFF, 5'd0, 5'd0);
    idle(3, 5'd0);

    drive(1, 1, 5'd9, 3'd2, 2'd0, 32'h11, 32'h11, 1, 5'd10, 32'h22, 5'd9, 5'd10);
    idle(1, 5'd9);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    idle(4, 5'd9);

    for (int i = 0; i < 400; i++) begin
      w   = $urandom;
      f3  = 3'($urandom_range(0, 7));
      off = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), f3, off,
            w, ext_model(f3, off, w), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(8, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
